// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority,
// MDU results queue in a small FIFO and a starvation timer forces a drain.
module wb_port_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pipe_we,
    input  logic [4:0]                 pipe_rd,
    input  logic [31:0]                pipe_data,
    input  logic                       mdu_valid,
    input  logic [4:0]                 mdu_rd,
    input  logic [31:0]                mdu_data,
    output logic                       mdu_ready,
    output logic                       pipe_stall,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [31:0]                rf_wdata,
    output logic [$clog2(DEPTH):0]     pend_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic {NORMAL = 1'b0, FORCE = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [WW-1:0]   wait_q, wait_d;
    logic [4:0]      mem_rd_q   [DEPTH];
    logic [31:0]     mem_data_q [DEPTH];
    logic            rf_we_q;
    logic [4:0]      rf_waddr_q;
    logic [31:0]     rf_wdata_q;

    logic            pipe_ok, fifo_nonempty;
    logic            accept, enq, deq, gnt_pipe;

    assign fifo_nonempty = (cnt_q != '0);
    assign pipe_ok       = pipe_we && (pipe_rd != 5'd0);
    assign mdu_ready     = (cnt_q != CW'(DEPTH));
    assign accept        = mdu_valid && mdu_ready;
    // x0 results are accepted (handshake completes) but never stored
    assign enq           = accept && (mdu_rd != 5'd0);

    // State register plus starvation counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= NORMAL;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next state: force a drain once the head has lost MAX_WAIT times
    always_comb begin
        state_d = NORMAL;
        wait_d  = '0;
        if (state_q == NORMAL && fifo_nonempty && !deq) begin
            if (wait_q + WW'(1) == WW'(MAX_WAIT)) begin
                state_d = FORCE;
            end else begin
                wait_d = wait_q + WW'(1);
            end
        end
    end

    // Outputs: stall in FORCE, pick the granted writer
    always_comb begin
        pipe_stall = 1'b0;
        gnt_pipe   = 1'b0;
        deq        = 1'b0;
        unique case (state_q)
            NORMAL: begin
                gnt_pipe = pipe_ok;
                deq      = !pipe_ok && fifo_nonempty;
            end
            FORCE: begin
                pipe_stall = 1'b1;
                deq        = fifo_nonempty;
            end
            default: ;
        endcase
    end

    // Occupancy count follows enqueue/dequeue
    always_comb begin
        cnt_d = cnt_q;
        if (enq && !deq) cnt_d = cnt_q + CW'(1);
        if (!enq && deq) cnt_d = cnt_q - CW'(1);
    end

    // FIFO pointers and count; reset drops every buffered entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (enq) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (deq) rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // FIFO storage, written at the tail
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_rd_q[wr_ptr_q]   <= mdu_rd;
            mem_data_q[wr_ptr_q] <= mdu_data;
        end
    end

    // Registered write port; address/data hold on idle cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= gnt_pipe || deq;
            if (gnt_pipe) begin
                rf_waddr_q <= pipe_rd;
                rf_wdata_q <= pipe_data;
            end else if (deq) begin
                rf_waddr_q <= mem_rd_q[rd_ptr_q];
                rf_wdata_q <= mem_data_q[rd_ptr_q];
            end
        end
    end

    // Dequeue from an empty FIFO or overfill must never happen
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(deq && !fifo_nonempty));
            assert (cnt_q <= CW'(DEPTH));
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: priority, x0 filtering,
// backpressure, starvation drain and mid-operation reset.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  pend_cnt;

    int n_cmp = 0;
    int n_err = 0;

    wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .pipe_we   (pipe_we),
        .pipe_rd   (pipe_rd),
        .pipe_data (pipe_data),
        .mdu_valid (mdu_valid),
        .mdu_rd    (mdu_rd),
        .mdu_data  (mdu_data),
        .mdu_ready (mdu_ready),
        .pipe_stall(pipe_stall),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .pend_cnt  (pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic we,
                          input logic [4:0] a, input logic [31:0] d);
        check({tag, ".we"}, 64'(rf_we), 64'(we));
        check({tag, ".addr"}, 64'(rf_waddr), 64'(a));
        check({tag, ".data"}, 64'(rf_wdata), 64'(d));
    endtask

    initial begin
        rst = 1'b1;
        pipe_we = 0; pipe_rd = 0; pipe_data = 0;
        mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
        step(); step();
        chk_wr("reset", 1'b0, 5'd0, 32'd0);
        check("reset.pend", 64'(pend_cnt), 64'd0);
        check("reset.stall", 64'(pipe_stall), 64'd0);
        check("reset.ready", 64'(mdu_ready), 64'd1);
        rst = 1'b0;

        // Pipeline only
        pipe_we = 1; pipe_rd = 5; pipe_data = 32'h11;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_wr("pipe", 1'b1, 5'd5, 32'h11);
            check("pipe.stall", 64'(pipe_stall), 64'd0);
            check("pipe.ready", 64'(mdu_ready), 64'd1);
        end
        pipe_we = 0;
        step();
        chk_wr("pipe.idle", 1'b0, 5'd5, 32'h11);

        // Idle-slot drain
        mdu_valid = 1; mdu_rd = 7; mdu_data = 32'hAB;
        step();
        mdu_valid = 0;
        check("drain.pend1", 64'(pend_cnt), 64'd1);
        check("drain.nowr", 64'(rf_we), 64'd0);
        step();
        chk_wr("drain", 1'b1, 5'd7, 32'hAB);
        check("drain.pend0", 64'(pend_cnt), 64'd0);

        // x0 filtering
        pipe_we = 1; pipe_rd = 0; pipe_data = 32'h99;
        step();
        check("x0.pipe", 64'(rf_we), 64'd0);
        pipe_we = 0;
        mdu_valid = 1; mdu_rd = 0; mdu_data = 32'h55;
        step();
        mdu_valid = 0;
        check("x0.mdu.pend", 64'(pend_cnt), 64'd0);
        step();
        chk_wr("x0.mdu", 1'b0, 5'd7, 32'hAB);

        // Backpressure then starvation drain
        pipe_we = 1; pipe_rd = 9; pipe_data = 32'h22;
        mdu_valid = 1; mdu_rd = 10; mdu_data = 32'hA1;
        step();
        mdu_rd = 11; mdu_data = 32'hA2;
        check("full.pend1", 64'(pend_cnt), 64'd1);
        step();
        mdu_rd = 12; mdu_data = 32'hA3;
        check("full.pend2", 64'(pend_cnt), 64'd2);
        check("full.ready", 64'(mdu_ready), 64'd0);
        chk_wr("full.pipe", 1'b1, 5'd9, 32'h22);
        for (int i = 0; i < 2; i++) begin
            step();
            check("starve.stall0", 64'(pipe_stall), 64'd0);
            check("starve.pend", 64'(pend_cnt), 64'd2);
            check("starve.ready", 64'(mdu_ready), 64'd0);
        end
        step();
        check("force.stall", 64'(pipe_stall), 64'd1);
        chk_wr("force.prev", 1'b1, 5'd9, 32'h22);
        step();
        check("force.once", 64'(pipe_stall), 64'd0);
        chk_wr("force.head", 1'b1, 5'd10, 32'hA1);
        check("force.pend", 64'(pend_cnt), 64'd1);
        check("force.ready", 64'(mdu_ready), 64'd1);
        step();
        chk_wr("resume.pipe", 1'b1, 5'd9, 32'h22);
        check("resume.pend", 64'(pend_cnt), 64'd2);
        mdu_valid = 0;
        pipe_we = 0;
        step();
        chk_wr("order.2", 1'b1, 5'd11, 32'hA2);
        check("order.pend1", 64'(pend_cnt), 64'd1);
        step();
        chk_wr("order.3", 1'b1, 5'd12, 32'hA3);
        check("order.pend0", 64'(pend_cnt), 64'd0);

        // Reset mid-operation with two entries buffered
        pipe_we = 1; pipe_rd = 9; pipe_data = 32'h33;
        mdu_valid = 1; mdu_rd = 13; mdu_data = 32'hB1;
        step();
        mdu_rd = 14; mdu_data = 32'hB2;
        step();
        mdu_valid = 0;
        check("rst.prefill", 64'(pend_cnt), 64'd2);
        rst = 1'b1;
        #1;
        check("rst.we", 64'(rf_we), 64'd0);
        check("rst.pend", 64'(pend_cnt), 64'd0);
        pipe_we = 0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rst.nobuf", 64'(rf_we), 64'd0);
        end
        pipe_we = 1; pipe_rd = 3; pipe_data = 32'h44;
        step();
        chk_wr("rst.after", 1'b1, 5'd3, 32'h44);
        pipe_we = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
